// File: rtl/gate_truth_checker.sv
// -----------------------------------------------------------------------------
// gate_truth_checker
//
// Self-checking driver for any 2-input logic gate model. A run applies the
// four input vectors {a,b} = 00, 01, 10, 11 in order. Each vector is held for
// SETTLE_CYCLES+1 cycles. The gate output y is sampled on the last edge of
// that window and compared against the matching bit of a latched 4-bit
// expected truth table. At the end of the run the block pulses done for one
// cycle and holds pass and the per-vector mismatch mask until the next start.
//
// Parameters:
//   SETTLE_CYCLES : cycles between applying a vector and sampling y (0 allowed)
//   CNT_W         : settle counter width; SETTLE_CYCLES must be < 2**CNT_W
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   begin a run (honoured only in IDLE)
//   truth_table  in   expected y per vector index {a,b}; bit0 = 00, bit3 = 11
//   y            in   output of the gate under test
//   a, b         out  registered gate inputs, always equal to vec_idx
//   busy         out  high while a run is in progress
//   done         out  one-cycle pulse at the end of a run
//   pass         out  last completed run had no mismatches
//   mismatch     out  bit i set if vector i mismatched
//   vec_idx      out  index of the vector currently applied
// -----------------------------------------------------------------------------
module gate_truth_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] truth_table,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] mismatch,
  output logic [1:0] vec_idx
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES);

  state_e           state_q,    state_d;
  logic [1:0]       vec_idx_q,  vec_idx_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [3:0]       exp_q,      exp_d;
  logic [3:0]       mismatch_q, mismatch_d;
  logic             pass_q,     pass_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d    = state_q;
    vec_idx_d  = vec_idx_q;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    mismatch_d = mismatch_q;
    pass_d     = pass_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy_d    = 1'b0;
        vec_idx_d = 2'd0;
        if (start) begin
          // The table is captured here so it can change freely during the run.
          exp_d      = truth_table;
          mismatch_d = 4'b0000;
          pass_d     = 1'b0;
          vec_idx_d  = 2'd0;
          cnt_d      = SETTLE_INIT;
          busy_d     = 1'b1;
          state_d    = S_RUN;
        end
      end

      S_RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Sample edge for the current vector.
          mismatch_d[vec_idx_q] = y ^ exp_q[vec_idx_q];
          if (vec_idx_q != 2'd3) begin
            vec_idx_d = vec_idx_q + 2'd1;
            cnt_d     = SETTLE_INIT;
          end else begin
            // pass uses the updated mask, so the last vector's bit counts too.
            pass_d    = (mismatch_d == 4'b0000);
            busy_d    = 1'b0;
            done_d    = 1'b1;
            vec_idx_d = 2'd0;
            state_d   = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        vec_idx_d = 2'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      vec_idx_q  <= 2'd0;
      cnt_q      <= '0;
      exp_q      <= 4'b0000;
      mismatch_q <= 4'b0000;
      pass_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_idx_q  <= vec_idx_d;
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      mismatch_q <= mismatch_d;
      pass_q     <= pass_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // The gate inputs come straight from the vector index flops, so {a,b}
  // always equals vec_idx and both are glitch-free register outputs.
  assign a        = vec_idx_q[1];
  assign b        = vec_idx_q[0];
  assign vec_idx  = vec_idx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign mismatch = mismatch_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// -----------------------------------------------------------------------------
// tb_gate_truth_checker
//
// Directed bench for gate_truth_checker. Instance dut uses SETTLE_CYCLES=2
// and drives a selectable behavioural gate model; instance dut0 uses
// SETTLE_CYCLES=0 and drives a plain AND gate. Expected values are worked out
// by hand from the vector order 00, 01, 10, 11 and the truth tables used.
// -----------------------------------------------------------------------------
module tb_gate_truth_checker;

  typedef enum logic [1:0] {G_XNOR, G_XOR, G_ONE, G_ZERO} gate_e;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] truth_table;
  logic       y;
  logic       a, b, busy, done, pass;
  logic [3:0] mismatch;
  logic [1:0] vec_idx;
  gate_e      gate;

  logic       start0;
  logic [3:0] tt0;
  logic       y0;
  logic       a0, b0, busy0, done0, pass0;
  logic [3:0] mismatch0;
  logic [1:0] vec_idx0;

  int n_chk = 0;
  int n_err = 0;

  gate_truth_checker #(.SETTLE_CYCLES(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .truth_table(truth_table),
    .y(y), .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
    .mismatch(mismatch), .vec_idx(vec_idx)
  );

  gate_truth_checker #(.SETTLE_CYCLES(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .truth_table(tt0),
    .y(y0), .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
    .mismatch(mismatch0), .vec_idx(vec_idx0)
  );

  // Gate models under test.
  always_comb begin
    y = 1'b0;
    case (gate)
      G_XNOR: y = ~(a ^ b);
      G_XOR:  y = a ^ b;
      G_ONE:  y = 1'b1;
      G_ZERO: y = 1'b0;
      default: y = 1'b0;
    endcase
  end
  assign y0 = a0 & b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full run on dut: start pulse, then check done timing and results.
  task automatic run_s2(input string tag, input logic [3:0] tbl,
                        input logic [3:0] exp_mm, input logic exp_pass);
    truth_table = tbl;
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy_acc"}, 8'(busy), 8'd1);
    check({tag, "_mm_clr"},   8'(mismatch), 8'h0);
    check({tag, "_pass_clr"}, 8'(pass), 8'd0);
    for (int k = 1; k < 12; k++) begin
      step();
      check({tag, "_done_early"}, 8'(done), 8'd0);
    end
    step();
    check({tag, "_done"},     8'(done), 8'd1);
    check({tag, "_busy_end"}, 8'(busy), 8'd0);
    check({tag, "_mm"},       8'(mismatch), 8'(exp_mm));
    check({tag, "_pass"},     8'(pass), 8'(exp_pass));
    step();
    check({tag, "_done_1cyc"}, 8'(done), 8'd0);
    check({tag, "_mm_hold"},   8'(mismatch), 8'(exp_mm));
    check({tag, "_pass_hold"}, 8'(pass), 8'(exp_pass));
  endtask

  initial begin
    int dcount;
    int dstep;

    rst_n       = 1'b0;
    start       = 1'b0;
    truth_table = 4'b0000;
    gate        = G_XNOR;
    start0      = 1'b0;
    tt0         = 4'b0000;

    // Reset state.
    #12;
    check("rst_a",        8'(a), 8'd0);
    check("rst_b",        8'(b), 8'd0);
    check("rst_busy",     8'(busy), 8'd0);
    check("rst_done",     8'(done), 8'd0);
    check("rst_pass",     8'(pass), 8'd0);
    check("rst_mismatch", 8'(mismatch), 8'h0);
    check("rst_vec_idx",  8'(vec_idx), 8'd0);
    rst_n = 1'b1;
    step();

    // XNOR with its own table: check the full vector sequence and latency.
    gate        = G_XNOR;
    truth_table = 4'b1001;
    start       = 1'b1;
    step();
    start = 1'b0;
    check("xnor_ab_e0",   8'({a, b}), 8'd0);
    check("xnor_busy_e0", 8'(busy), 8'd1);
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k < 12) begin
        check($sformatf("xnor_ab_e%0d", k), 8'({a, b}), 8'(k / 3));
        check($sformatf("xnor_vi_e%0d", k), 8'(vec_idx), 8'(k / 3));
        check($sformatf("xnor_done_e%0d", k), 8'(done), 8'd0);
      end
    end
    check("xnor_done", 8'(done), 8'd1);
    check("xnor_busy", 8'(busy), 8'd0);
    check("xnor_ab",   8'({a, b}), 8'd0);
    check("xnor_pass", 8'(pass), 8'd1);
    check("xnor_mm",   8'(mismatch), 8'h0);
    step();
    check("xnor_done_low", 8'(done), 8'd0);
    step();

    // XOR against the XNOR table: every vector wrong.
    gate = G_XOR;
    run_s2("xor", 4'b1001, 4'b1111, 1'b0);

    // y stuck at 1: vectors 01 and 10 wrong.
    gate = G_ONE;
    run_s2("one", 4'b1001, 4'b0110, 1'b0);

    // y stuck at 0 with an all-zero table: previous mask must be cleared.
    gate = G_ZERO;
    run_s2("zero", 4'b0000, 4'b0000, 1'b1);

    // SETTLE_CYCLES=0 instance with AND: one cycle per vector, done after 4.
    tt0    = 4'b1000;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    check("and_ab_e0", 8'({a0, b0}), 8'd0);
    step();
    check("and_ab_e1", 8'({a0, b0}), 8'd1);
    step();
    check("and_ab_e2", 8'({a0, b0}), 8'd2);
    step();
    check("and_ab_e3", 8'({a0, b0}), 8'd3);
    check("and_done_e3", 8'(done0), 8'd0);
    step();
    check("and_done", 8'(done0), 8'd1);
    check("and_pass", 8'(pass0), 8'd1);
    check("and_mm",   8'(mismatch0), 8'h0);
    step();
    check("and_done_low", 8'(done0), 8'd0);

    // start re-pulsed and table flipped mid-run: no effect on the run.
    gate        = G_XNOR;
    truth_table = 4'b1001;
    start       = 1'b1;
    step();
    start  = 1'b0;
    dcount = 0;
    dstep  = -1;
    for (int k = 1; k <= 16; k++) begin
      if (k >= 4 && k <= 6) begin
        start       = 1'b1;
        truth_table = 4'b0110;
      end else begin
        start = 1'b0;
      end
      step();
      if (done) begin
        dcount++;
        dstep = k;
      end
    end
    check("mid_done_count", 8'(dcount), 8'd1);
    check("mid_done_edge",  8'(dstep), 8'd12);
    check("mid_pass",       8'(pass), 8'd1);
    check("mid_mm",         8'(mismatch), 8'h0);

    // start held continuously: back-to-back runs one idle cycle apart.
    truth_table = 4'b1001;
    start       = 1'b1;
    step();
    for (int k = 1; k <= 12; k++) step();
    check("held_done",  8'(done), 8'd1);
    step();
    check("held_idle",  8'(busy), 8'd0);
    step();
    check("held_restart", 8'(busy), 8'd1);
    start = 1'b0;
    for (int k = 1; k <= 13; k++) step();

    // Reset mid-run while vec_idx==2, with a mismatch already recorded.
    gate        = G_ONE;
    truth_table = 4'b1001;
    start       = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 6; k++) step();
    check("rmr_vec_idx", 8'(vec_idx), 8'd2);
    check("rmr_mm_pre",  8'(mismatch), 8'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    check("rmr_a",    8'(a), 8'd0);
    check("rmr_b",    8'(b), 8'd0);
    check("rmr_busy", 8'(busy), 8'd0);
    check("rmr_pass", 8'(pass), 8'd0);
    check("rmr_mm",   8'(mismatch), 8'h0);
    step();
    rst_n  = 1'b1;
    dcount = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (done) dcount++;
    end
    check("rmr_no_done", 8'(dcount), 8'd0);
    gate = G_XNOR;
    run_s2("after_rst", 4'b1001, 4'b0000, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
